// File: rtl/diode_sweep_ctrl.sv
// diode_sweep_ctrl: ramps a DAC code, writes it over SPI, settles, then listens for noise and latches a calibration code
// Ports: clk, reset_n (async active-low); start/abort control; noise_valid from the noise detector;
//        spi_done/spi_start/dac_code to the SPI DAC driver; store_en/cal_code to the calibration store;
//        busy and fail status. Defining SWEEP_DEBUG_EN adds debug_state, debug_windows and debug_hits.
module diode_sweep_ctrl #(
  parameter int DAC_W           = 8,
  parameter int STEP            = 1,
  parameter int V_MAX           = 2**DAC_W - 1,
  parameter int MARGIN          = 2,
  parameter int SETTLE_TICKS    = 19000,
  parameter int WINDOW_TICKS    = 5750,
  parameter int MIN_HITS        = 1,
  parameter int CONFIRM_WINDOWS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             noise_valid,
  input  logic             spi_done,
  output logic [DAC_W-1:0] dac_code,
  output logic             spi_start,
  output logic             store_en,
  output logic [DAC_W-1:0] cal_code,
  output logic             busy,
  output logic             fail
`ifdef SWEEP_DEBUG_EN
  ,
  output logic [2:0]                           debug_state,
  output logic [$clog2(CONFIRM_WINDOWS+1)-1:0] debug_windows,
  output logic [15:0]                          debug_hits
`endif
);
  localparam int TMAX = SETTLE_TICKS > WINDOW_TICKS ? SETTLE_TICKS : WINDOW_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int HW   = $clog2(MIN_HITS + 1);
  localparam int WW   = $clog2(CONFIRM_WINDOWS + 1);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT_SPI, S_SETTLE, S_LISTEN, S_EVAL, S_DONE, S_FAIL} state_t;
  state_t           r_state, w_next;
  logic [DAC_W-1:0] r_dac, r_cal;
  logic             r_fail, r_nv_prev;
  logic [TW-1:0]    r_timer;
  logic [HW-1:0]    r_hits;
  logic [WW-1:0]    r_win;
  logic [DAC_W:0]   w_dac_inc;
  logic             w_idle, w_edge, w_noisy, w_confirm, w_top, w_settle_end, w_listen_end;
  assign w_idle       = r_state inside {S_IDLE, S_DONE, S_FAIL};
  assign w_edge       = (r_state == S_LISTEN) && noise_valid && !r_nv_prev;
  assign w_noisy      = r_hits >= HW'(MIN_HITS);
  assign w_confirm    = r_win + 1'b1 == WW'(CONFIRM_WINDOWS);
  // one extra bit so the top-of-range test cannot wrap
  assign w_dac_inc    = {1'b0, r_dac} + (DAC_W+1)'(STEP);
  assign w_top        = w_dac_inc > (DAC_W+1)'(V_MAX);
  assign w_settle_end = r_timer == TW'(SETTLE_TICKS - 1);
  assign w_listen_end = r_timer == TW'(WINDOW_TICKS - 1);
  assign dac_code     = r_dac;
  assign cal_code     = r_cal;
  assign fail         = r_fail;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: w_next = start ? S_WRITE : r_state;
      S_WRITE:                w_next = S_WAIT_SPI;
      S_WAIT_SPI:             w_next = spi_done ? S_SETTLE : S_WAIT_SPI;
      S_SETTLE:               w_next = w_settle_end ? S_LISTEN : S_SETTLE;
      S_LISTEN:               w_next = w_listen_end ? S_EVAL : S_LISTEN;
      S_EVAL:                 w_next = w_noisy ? (w_confirm ? S_DONE : S_SETTLE) : (w_top ? S_FAIL : S_WRITE);
    endcase
    if (abort) w_next = S_IDLE;
    // abort suppresses any strobe that would otherwise leave on this cycle
    spi_start = (r_state == S_WRITE) && !abort;
    store_en  = (r_state == S_EVAL) && w_noisy && w_confirm && !abort;
    busy      = !w_idle;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dac     <= '0;
      r_cal     <= '0;
      r_fail    <= 1'b0;
      r_nv_prev <= 1'b0;
      r_timer   <= '0;
      r_hits    <= '0;
      r_win     <= '0;
    end else if (abort) begin
      r_dac     <= '0;
      r_fail    <= 1'b0;
      r_nv_prev <= 1'b0;
      r_timer   <= '0;
      r_hits    <= '0;
      r_win     <= '0;
    end else begin
      // edge history only lives inside a window, so each window starts from a clear sample
      r_nv_prev <= (r_state == S_LISTEN) && noise_valid;
      r_timer   <= ((r_state == S_SETTLE && !w_settle_end) || (r_state == S_LISTEN && !w_listen_end)) ? r_timer + 1'b1 : '0;
      r_hits    <= (r_state == S_SETTLE) ? '0 : (w_edge && !w_noisy) ? r_hits + 1'b1 : r_hits;
      if (w_idle && start) begin
        r_dac  <= '0;
        r_win  <= '0;
        r_fail <= 1'b0;
      end
      if (r_state == S_EVAL) begin
        if (w_noisy && w_confirm) r_cal <= (r_dac >= DAC_W'(MARGIN)) ? r_dac - DAC_W'(MARGIN) : '0;
        r_win <= (w_noisy && !w_confirm) ? r_win + 1'b1 : '0;
        if (!w_noisy && w_top) r_fail <= 1'b1;
        if (!w_noisy && !w_top) r_dac <= w_dac_inc[DAC_W-1:0];
      end
    end
  end
`ifdef SWEEP_DEBUG_EN
  logic        r_dbg_prev;
  logic [15:0] r_dbg_hits;
  assign debug_state   = r_state;
  assign debug_windows = r_win;
  assign debug_hits    = r_dbg_hits;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dbg_prev <= 1'b0;
      r_dbg_hits <= '0;
    end else begin
      r_dbg_prev <= noise_valid;
      if (w_idle && start && !abort) r_dbg_hits <= '0;
      else if (busy && noise_valid && !r_dbg_prev && !(&r_dbg_hits)) r_dbg_hits <= r_dbg_hits + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_diode_sweep_ctrl.sv
// tb_diode_sweep_ctrl: randomized bench for diode_sweep_ctrl against a window-level sweep model
module tb_diode_sweep_ctrl;
  localparam int ST = 4;
  localparam int WT = 6;
  localparam int MG = 2;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] start_v, abort_v, nv_v, sd_v, spi_v, store_v, busy_v, fail_v;
  logic [7:0] dac_v [3];
  logic [7:0] cal_v [3];
  logic [7:0] model_cal [3];
  int p_step [3] = '{1, 4, 1};
  int p_vmax [3] = '{255, 20, 255};
  int p_minh [3] = '{1, 1, 2};
  int n_checks = 0;
  int n_fail = 0;
  logic [19:0] exp_q [$];
  bit nv_q [$];
  bit sd_q [$];
  bit st_q [$];
  always #5 clk = ~clk;
  diode_sweep_ctrl #(.DAC_W(8), .STEP(1), .V_MAX(255), .MARGIN(MG), .SETTLE_TICKS(ST), .WINDOW_TICKS(WT), .MIN_HITS(1), .CONFIRM_WINDOWS(CW)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]), .noise_valid(nv_v[0]), .spi_done(sd_v[0]),
    .dac_code(dac_v[0]), .spi_start(spi_v[0]), .store_en(store_v[0]), .cal_code(cal_v[0]), .busy(busy_v[0]), .fail(fail_v[0]));
  diode_sweep_ctrl #(.DAC_W(8), .STEP(4), .V_MAX(20), .MARGIN(MG), .SETTLE_TICKS(ST), .WINDOW_TICKS(WT), .MIN_HITS(1), .CONFIRM_WINDOWS(CW)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]), .noise_valid(nv_v[1]), .spi_done(sd_v[1]),
    .dac_code(dac_v[1]), .spi_start(spi_v[1]), .store_en(store_v[1]), .cal_code(cal_v[1]), .busy(busy_v[1]), .fail(fail_v[1]));
  diode_sweep_ctrl #(.DAC_W(8), .STEP(1), .V_MAX(255), .MARGIN(MG), .SETTLE_TICKS(ST), .WINDOW_TICKS(WT), .MIN_HITS(2), .CONFIRM_WINDOWS(CW)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort_v[2]), .noise_valid(nv_v[2]), .spi_done(sd_v[2]),
    .dac_code(dac_v[2]), .spi_start(spi_v[2]), .store_en(store_v[2]), .cal_code(cal_v[2]), .busy(busy_v[2]), .fail(fail_v[2]));
  function automatic logic [19:0] obs(input int k);
    return {busy_v[k], spi_v[k], store_v[k], fail_v[k], dac_v[k], cal_v[k]};
  endfunction
  function automatic bit rb(input bit en);
    return en && ($urandom_range(0, 1) == 1);
  endfunction
  function automatic int n_edges(input logic [WT-1:0] p);
    int n = 0;
    for (int i = 0; i < WT; i++) if (p[i] && (i == 0 || !p[i-1])) n++;
    return n;
  endfunction
  function automatic logic [WT-1:0] gen_pat(input int e);
    logic [WT-1:0] p = '0;
    logic [WT-1:0] q;
    bit found = (e == 0);
    for (int i = 0; i < 2000; i++) begin
      if (!found) begin
        q = WT'($urandom);
        if (n_edges(q) == e) begin
          p = q;
          found = 1;
        end
      end
    end
    return p;
  endfunction
  // edges wanted in window j at a given code, per scenario
  function automatic int want(input int scen, input int code, input int j);
    case (scen)
      1: return code >= 10 ? int'($urandom_range(1, 3)) : 0;
      2: return ((code == 5 && j < 2) || code == 7) ? int'($urandom_range(1, 3)) : 0;
      4: return int'($urandom_range(1, 3));
      5: return code < 3 ? 1 : (code == 3 ? int'($urandom_range(2, 3)) : 0);
      6: return ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
      default: return 0;
    endcase
  endfunction
  function automatic void add(input logic [19:0] e, input bit n, input bit s, input bit t);
    exp_q.push_back(e);
    nv_q.push_back(n);
    sd_q.push_back(s);
    st_q.push_back(t);
  endfunction
  // builds the expected per-cycle outputs of one sweep from phase durations, then drives and compares it
  task automatic run(input int k, input int scen, input int abort_at, input string name);
    int code = 0;
    int streak = 0;
    int j;
    int at;
    int store_idx = -1;
    bit finished = 0;
    bit moved;
    bit noisy;
    bit stopped = 0;
    bit en = (scen != 3);
    logic [7:0] cal_new = model_cal[k];
    logic [7:0] pc;
    logic [WT-1:0] pat;
    exp_q.delete();
    nv_q.delete();
    sd_q.delete();
    st_q.delete();
    while (!finished) begin
      pc = 8'(code);
      add({4'b1100, pc, model_cal[k]}, rb(en), rb(1), 0);
      add({4'b1000, pc, model_cal[k]}, rb(en), 0, 0);
      add({4'b1000, pc, model_cal[k]}, rb(en), 1, 0);
      j = 0;
      moved = 0;
      while (!moved && !finished) begin
        for (int i = 0; i < ST; i++)
          add({4'b1000, pc, model_cal[k]}, (scen == 1 && code == 10 && j == 1 && i == ST-1) ? 1'b1 : rb(en), rb(1), scen == 6 && $urandom_range(0, 3) == 0);
        pat = (scen == 1 && code == 10 && j == 0) ? WT'(6'b100000) : (scen == 1 && code == 10 && j == 1) ? WT'(6'b000001) : gen_pat(want(scen, code, j));
        for (int i = 0; i < WT; i++) add({4'b1000, pc, model_cal[k]}, pat[i], rb(1), 0);
        noisy = n_edges(pat) >= p_minh[k];
        if (noisy && streak + 1 == CW) begin
          store_idx = exp_q.size();
          add({4'b1010, pc, model_cal[k]}, rb(en), rb(1), 0);
          cal_new = code >= MG ? 8'(code - MG) : 8'd0;
          repeat (2) add({4'b0000, pc, cal_new}, rb(en), rb(1), 0);
          finished = 1;
        end else if (noisy) begin
          streak++;
          j++;
          add({4'b1000, pc, model_cal[k]}, rb(en), rb(1), 0);
        end else begin
          streak = 0;
          add({4'b1000, pc, model_cal[k]}, rb(en), rb(1), 0);
          if (code + p_step[k] > p_vmax[k]) begin
            repeat (2) add({4'b0001, pc, model_cal[k]}, rb(en), rb(1), 0);
            finished = 1;
          end else begin
            code += p_step[k];
            moved = 1;
          end
        end
      end
    end
    at = abort_at == -2 ? store_idx : abort_at;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    for (int t = 0; t < exp_q.size() && !stopped; t++) begin
      n_checks++;
      if (obs(k) !== exp_q[t]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {busy,spi,store,fail,dac,cal} got %h expected %h", name, t, obs(k), exp_q[t]);
      end
      if (t == at) begin
        abort_v[k] = 1'b1;
        start_v[k] = 1'b1;
        #1;
        n_checks++;
        if ({spi_v[k], store_v[k]} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s abort-cycle strobes: got %b expected 00", name, {spi_v[k], store_v[k]});
        end
        @(posedge clk);
        #1;
        abort_v[k] = 1'b0;
        start_v[k] = 1'b0;
        repeat (2) begin
          n_checks++;
          if (obs(k) !== {12'h000, model_cal[k]}) begin
            n_fail++;
            $display("FAIL %s after abort: got %h expected %h", name, obs(k), {12'h000, model_cal[k]});
          end
          @(posedge clk);
          #1;
        end
        stopped = 1;
      end else begin
        nv_v[k] = nv_q[t];
        sd_v[k] = sd_q[t];
        start_v[k] = st_q[t];
        @(posedge clk);
        #1;
      end
    end
    nv_v[k] = 1'b0;
    sd_v[k] = 1'b0;
    start_v[k] = 1'b0;
    if (!stopped) model_cal[k] = cal_new;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== 20'h0) begin
        n_fail++;
        $display("FAIL reset inst %0d: got %h expected 00000", k, obs(k));
      end
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic();
    run(0, 1, -1, "basic");
    n_checks++;
    if ({busy_v[0], cal_v[0]} !== {1'b0, 8'd8}) begin
      n_fail++;
      $display("FAIL basic result: got busy=%b cal=%0d expected busy=0 cal=8", busy_v[0], cal_v[0]);
    end
  endtask
  task automatic test_back_to_back();
    run(0, 4, -1, "margin_sat");
    n_checks++;
    if (cal_v[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL margin_sat cal: got %0d expected 0", cal_v[0]);
    end
  endtask
  task automatic test_broken_streak();
    run(0, 2, -1, "broken_streak");
    n_checks++;
    if (cal_v[0] !== 8'd5) begin
      n_fail++;
      $display("FAIL broken_streak cal: got %0d expected 5", cal_v[0]);
    end
  endtask
  task automatic test_abort();
    run(0, 1, ST + 5, "abort_listen");
    run(0, 1, 0, "abort_write");
    run(0, 4, -2, "abort_store");
    n_checks++;
    if (cal_v[0] !== 8'd5) begin
      n_fail++;
      $display("FAIL abort cal kept: got %0d expected 5", cal_v[0]);
    end
  endtask
  task automatic test_reset_mid();
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (obs(0) !== {12'h800, model_cal[0]}) begin
      n_fail++;
      $display("FAIL reset_mid settle: got %h expected %h", obs(0), {12'h800, model_cal[0]});
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs(0) !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid async: got %h expected 00000", obs(0));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_cal = '{default: 8'd0};
    @(posedge clk);
    #1;
  endtask
  task automatic test_failure();
    repeat (2) begin
      run(1, 3, -1, "failure");
      n_checks++;
      if ({fail_v[1], store_v[1], dac_v[1]} !== {1'b1, 1'b0, 8'd20}) begin
        n_fail++;
        $display("FAIL failure end: got fail=%b store=%b dac=%0d expected fail=1 store=0 dac=20", fail_v[1], store_v[1], dac_v[1]);
      end
    end
  endtask
  task automatic test_min_hits();
    run(2, 5, -1, "min_hits");
    n_checks++;
    if (cal_v[2] !== 8'd1) begin
      n_fail++;
      $display("FAIL min_hits cal: got %0d expected 1", cal_v[2]);
    end
  endtask
  task automatic test_random();
    for (int r = 0; r < 3; r++) run(0, 6, -1, "random");
  endtask
  initial begin
    start_v = '0;
    abort_v = '0;
    nv_v = '0;
    sd_v = '0;
    model_cal = '{default: 8'd0};
    test_reset();
    test_basic();
    test_back_to_back();
    test_broken_streak();
    test_abort();
    test_reset_mid();
    test_failure();
    test_min_hits();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
